// File: rtl/sys_key_conditioner.sv
// rtl/sys_key_conditioner.sv - key/switch sync+debounce, single-step clock, CPU reset and step counter; optional auto-run via STEP_AUTORUN_EN

// Two-flop synchroniser followed by a counting debouncer for one raw input.
module sys_key_conditioner_db #(
  parameter int   DB_MAX    = 250000,
  parameter logic RST_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic level
);

  localparam int            CW       = $clog2(DB_MAX) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_MAX - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous input into the clock domain; reset to the idle level so no count starts.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= RST_LEVEL;
      sync2 <= RST_LEVEL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; any agreeing cycle restarts the count, so glitches never flip the level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      level <= RST_LEVEL;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

module sys_key_conditioner #(
  parameter int DB_MAX   = 250000,
  parameter int STRETCH  = 4,
  parameter int AUTO_DIV = 25000000
) (
  input  logic        SYS_clk_in,
  input  logic        SYS_rst,
  input  logic        KEY_step_n,
  input  logic        KEY_rst_n,
  input  logic        SW_load,
  input  logic        SW_run,
  output logic        STEP_pulse,
  output logic        STEP_clk,
  output logic        CPU_rst_n,
  output logic        LOAD_lvl,
  output logic [15:0] STEP_count,
  output logic        BUSY
);

  typedef enum logic {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_t;

  localparam int             SCW          = (STRETCH > 1) ? $clog2(STRETCH) : 1;
  localparam logic [SCW-1:0] STRETCH_LOAD = SCW'(STRETCH - 1);

  logic           step_db;
  logic           rst_db;
  logic           load_db;
  logic           step_prev;
  logic           manual_req;
  logic           step_req;
  logic           step_fire;
  logic           cpu_rst_n_q;
  logic           load_lvl_q;
  logic           step_pulse_q;
  logic           step_clk_q;
  state_t         state;
  logic [SCW-1:0] stretch_cnt;
  logic [15:0]    step_count_q;
  logic [15:0]    step_count_d;

  sys_key_conditioner_db #(.DB_MAX(DB_MAX), .RST_LEVEL(1'b1)) u_step_db (
    .clk    (SYS_clk_in),
    .resetn (SYS_rst),
    .raw    (KEY_step_n),
    .level  (step_db)
  );

  sys_key_conditioner_db #(.DB_MAX(DB_MAX), .RST_LEVEL(1'b1)) u_rst_db (
    .clk    (SYS_clk_in),
    .resetn (SYS_rst),
    .raw    (KEY_rst_n),
    .level  (rst_db)
  );

  sys_key_conditioner_db #(.DB_MAX(DB_MAX), .RST_LEVEL(1'b0)) u_load_db (
    .clk    (SYS_clk_in),
    .resetn (SYS_rst),
    .raw    (SW_load),
    .level  (load_db)
  );

  // Register the clean CPU reset and load level, and keep the previous step level for press detection.
  always_ff @(posedge SYS_clk_in) begin
    if (!SYS_rst) begin
      cpu_rst_n_q <= 1'b0;
      load_lvl_q  <= 1'b0;
      step_prev   <= 1'b1;
    end else begin
      cpu_rst_n_q <= rst_db;
      load_lvl_q  <= load_db;
      step_prev   <= step_db;
    end
  end

  // Only the released-to-pressed transition of the debounced key is a step request.
  assign manual_req = step_prev & ~step_db;

`ifdef STEP_AUTORUN_EN
  localparam int            DW       = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(AUTO_DIV - 1);

  logic          run_db;
  logic          auto_req;
  logic [DW-1:0] div_cnt;

  sys_key_conditioner_db #(.DB_MAX(DB_MAX), .RST_LEVEL(1'b0)) u_run_db (
    .clk    (SYS_clk_in),
    .resetn (SYS_rst),
    .raw    (SW_run),
    .level  (run_db)
  );

  // Free-running step divider, held at zero unless running and out of CPU reset.
  always_ff @(posedge SYS_clk_in) begin
    if (!SYS_rst || !run_db || !cpu_rst_n_q) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign auto_req = run_db & cpu_rst_n_q & (div_cnt == DIV_LAST);
  assign step_req = run_db ? auto_req : manual_req;
`else
  logic sw_run_unused;

  assign sw_run_unused = SW_run;
  assign step_req      = manual_req;
`endif

  assign step_fire = (state == IDLE) & step_req & cpu_rst_n_q & ~load_lvl_q;

  // Next step count: cleared while the CPU is in reset, bumped on every issued step, wraps naturally.
  always_comb begin
    step_count_d = step_count_q;
    if (!cpu_rst_n_q) begin
      step_count_d = '0;
    end else if (step_fire) begin
      step_count_d = step_count_q + 16'd1;
    end
  end

  // Step FSM: one strobe per request, then hold the step clock high for STRETCH cycles.
  always_ff @(posedge SYS_clk_in) begin
    if (!SYS_rst) begin
      state        <= IDLE;
      stretch_cnt  <= '0;
      step_pulse_q <= 1'b0;
      step_clk_q   <= 1'b0;
      step_count_q <= '0;
    end else begin
      step_count_q <= step_count_d;
      step_pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (step_fire) begin
            state        <= HIGH;
            step_pulse_q <= 1'b1;
            step_clk_q   <= 1'b1;
            stretch_cnt  <= STRETCH_LOAD;
          end
        end
        HIGH: begin
          if (!cpu_rst_n_q || (stretch_cnt == '0)) begin
            state      <= IDLE;
            step_clk_q <= 1'b0;
          end else begin
            stretch_cnt <= stretch_cnt - 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          step_clk_q <= 1'b0;
        end
      endcase
    end
  end

  assign STEP_pulse = step_pulse_q;
  assign STEP_clk   = step_clk_q;
  assign BUSY       = step_clk_q;
  assign CPU_rst_n  = cpu_rst_n_q;
  assign LOAD_lvl   = load_lvl_q;
  assign STEP_count = step_count_q;

endmodule

// File: tb/tb_sys_key_conditioner.sv
// tb/tb_sys_key_conditioner.sv - self-checking bench for sys_key_conditioner

module tb_sys_key_conditioner;

  logic        clk;
  logic        SYS_rst;
  logic        KEY_step_n;
  logic        KEY_rst_n;
  logic        SW_load;
  logic        SW_run;
  logic        STEP_pulse;
  logic        STEP_clk;
  logic        CPU_rst_n;
  logic        LOAD_lvl;
  logic [15:0] STEP_count;
  logic        BUSY;

  int checks;
  int failures;
  int exp_count;
  int at;
  int n;

  typedef struct {
    logic        key;
    logic        pulse;
    logic        sclk;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[20];

  sys_key_conditioner #(.DB_MAX(4), .STRETCH(2), .AUTO_DIV(8)) dut (
    .SYS_clk_in (clk),
    .SYS_rst    (SYS_rst),
    .KEY_step_n (KEY_step_n),
    .KEY_rst_n  (KEY_rst_n),
    .SW_load    (SW_load),
    .SW_run     (SW_run),
    .STEP_pulse (STEP_pulse),
    .STEP_clk   (STEP_clk),
    .CPU_rst_n  (CPU_rst_n),
    .LOAD_lvl   (LOAD_lvl),
    .STEP_count (STEP_count),
    .BUSY       (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_pulse(input int limit, output int first_at, output int npulse);
    first_at = -1;
    npulse   = 0;
    for (int t = 1; t <= limit; t++) begin
      tick();
      if (STEP_pulse) begin
        npulse++;
        if (first_at < 0) first_at = t;
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_count  = 0;
    SYS_rst    = 1'b0;
    KEY_step_n = 1'b1;
    KEY_rst_n  = 1'b1;
    SW_load    = 1'b0;
    SW_run     = 1'b0;

    // Clean press: key held low for 10 cycles, then released for 10.
    for (int i = 0; i < 20; i++) begin
      tbl[i].key   = (i < 10) ? 1'b0 : 1'b1;
      tbl[i].pulse = (i == 6) ? 1'b1 : 1'b0;
      tbl[i].sclk  = (i == 6 || i == 7) ? 1'b1 : 1'b0;
      tbl[i].cnt   = (i >= 6) ? 16'd1 : 16'd0;
    end

    // Reset
    repeat (3) tick();
    check("rst_pulse", STEP_pulse, 0);
    check("rst_clk", STEP_clk, 0);
    check("rst_busy", BUSY, 0);
    check("rst_cpu", CPU_rst_n, 0);
    check("rst_load", LOAD_lvl, 0);
    check("rst_count", STEP_count, 0);
    SYS_rst = 1'b1;
    tick();
    check("post_rst_cpu", CPU_rst_n, 1);
    check("post_rst_count", STEP_count, 0);
    repeat (3) tick();

    // Clean press table
    for (int i = 0; i < 20; i++) begin
      KEY_step_n = tbl[i].key;
      tick();
      check($sformatf("press_pulse[%0d]", i), STEP_pulse, tbl[i].pulse);
      check($sformatf("press_clk[%0d]", i), STEP_clk, tbl[i].sclk);
      check($sformatf("press_busy[%0d]", i), BUSY, tbl[i].sclk);
      check($sformatf("press_count[%0d]", i), STEP_count, tbl[i].cnt);
    end
    exp_count = 1;

    // Bounce: 2-cycle toggles never settle, then a stable press gives exactly one step
    n = 0;
    for (int i = 0; i < 20; i++) begin
      KEY_step_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (STEP_pulse) n++;
    end
    check("bounce_no_pulse", n, 0);
    KEY_step_n = 1'b0;
    wait_pulse(20, at, n);
    check("bounce_pulse_at", at, 7);
    check("bounce_pulse_n", n, 1);
    exp_count++;
    check("bounce_count", STEP_count, exp_count);
    KEY_step_n = 1'b1;
    repeat (10) tick();

    // Reset key pressed together with the step key: CPU reset lands during the high phase
    KEY_step_n = 1'b0;
    KEY_rst_n  = 1'b0;
    repeat (6) tick();
    check("rk_cpu_before", CPU_rst_n, 1);
    tick();
    check("rk_pulse", STEP_pulse, 1);
    check("rk_clk", STEP_clk, 1);
    check("rk_cpu_low", CPU_rst_n, 0);
    check("rk_count_inc", STEP_count, exp_count + 1);
    tick();
    check("rk_clk_drop", STEP_clk, 0);
    check("rk_count_clr", STEP_count, 0);
    exp_count = 0;
    KEY_step_n = 1'b1;
    repeat (10) tick();
    KEY_step_n = 1'b0;
    wait_pulse(15, at, n);
    check("rk_no_pulse", n, 0);
    check("rk_count_held", STEP_count, 0);
    check("rk_cpu_held", CPU_rst_n, 0);
    KEY_step_n = 1'b1;
    repeat (10) tick();
    KEY_rst_n = 1'b1;
    repeat (6) tick();
    check("rk_cpu_still_low", CPU_rst_n, 0);
    tick();
    check("rk_cpu_back", CPU_rst_n, 1);
    repeat (3) tick();

    // Wrap: preset the counter to all-ones, then step
    force dut.step_count_q = 16'hFFFF;
    tick();
    release dut.step_count_q;
    tick();
    check("wrap_preset", STEP_count, 16'hFFFF);
    KEY_step_n = 1'b0;
    wait_pulse(7, at, n);
    check("wrap_pulse_at", at, 7);
    check("wrap_count", STEP_count, 0);
    KEY_step_n = 1'b1;
    repeat (10) tick();

    // Load inhibit
    SW_load = 1'b1;
    repeat (6) tick();
    check("load_lvl_before", LOAD_lvl, 0);
    tick();
    check("load_lvl_high", LOAD_lvl, 1);
    KEY_step_n = 1'b0;
    wait_pulse(15, at, n);
    check("load_no_pulse", n, 0);
    check("load_count", STEP_count, 0);
    KEY_step_n = 1'b1;
    repeat (10) tick();
    SW_load = 1'b0;
    repeat (10) tick();
    check("load_lvl_low", LOAD_lvl, 0);

`ifdef STEP_AUTORUN_EN
    // Auto-run: first step after debounce plus one full divider period, then every 8 cycles
    SW_run = 1'b1;
    wait_pulse(20, at, n);
    check("auto_first_at", at, 14);
    check("auto_first_n", n, 1);
    for (int g = 0; g < 3; g++) begin
      if (g == 0) KEY_step_n = 1'b0;
      if (g == 2) KEY_step_n = 1'b1;
      wait_pulse(8, at, n);
      check($sformatf("auto_gap_at[%0d]", g), at, 8);
      check($sformatf("auto_gap_n[%0d]", g), n, 1);
    end
    SW_run = 1'b0;
    exp_count += 4;
    wait_pulse(30, at, n);
    check("auto_stopped", n, 0);
    check("auto_count", STEP_count, exp_count);
`else
    // Without auto-run the run switch has no effect on manual stepping
    SW_run = 1'b1;
    repeat (10) tick();
    KEY_step_n = 1'b0;
    wait_pulse(15, at, n);
    check("run_ignored_at", at, 7);
    check("run_ignored_n", n, 1);
    exp_count++;
    check("run_ignored_count", STEP_count, exp_count);
    KEY_step_n = 1'b1;
    SW_run     = 1'b0;
    repeat (10) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
